// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access
// size codes and the request legality check used at acceptance.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned DEPTH_DEFAULT = 128;

    // Misaligned, illegal size, or word index beyond the attached memory.
    function automatic logic req_is_bad(input logic [1:0] size,
                                        input logic [31:0] addr,
                                        input int unsigned depth);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = |addr[1:0];
            default: bad = 1'b1;
        endcase
        return bad || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// CPU request/response and memory-side signals of the LSU; the LSU takes the
// slave view, the environment (CPU + memory) the master view.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ReadData,
        input  req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, Address, WriteData
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ReadData,
        output req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, Address, WriteData
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: merges store data into a captured word and
// extracts/extends load data from it.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = word_i[{offset_i[1], 4'b0000} +: 16];
        merged_o = wdata_i;
        load_o   = word_i;
        case (size_i)
            SZ_BYTE: begin
                merged_o = word_i;
                merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
                load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                merged_o = word_i;
                merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one request at a time, loads via READ, word stores via
// WRITE, sub-word stores via read-modify-write, then a one-cycle response.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input logic      clk,
    input logic      rst,
    mem_lsu_if.slave bus
);
    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, word_q;
    logic [1:0]  size_q;
    logic        write_q, unsigned_q, err_q;
    logic        accept, req_err;
    logic [31:0] merged, load_data;

    assign accept  = (state_q == ST_IDLE) && bus.req_valid;
    assign req_err = req_is_bad(bus.req_size, bus.req_addr, DEPTH);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                                  state_d = ST_RESP;
                    else if (bus.req_write && bus.req_size == SZ_WORD) state_d = ST_WRITE;
                    else                                          state_d = ST_READ;
                end
            end
            ST_READ:  state_d = write_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= bus.req_addr;
                wdata_q    <= bus.req_wdata;
                size_q     <= bus.req_size;
                write_q    <= bus.req_write;
                unsigned_q <= bus.req_unsigned;
                err_q      <= req_err;
            end
            if (state_q == ST_READ) word_q <= bus.ReadData;
        end
    end

    mem_lane_align u_align (
        .word_i     (word_q),
        .wdata_i    (wdata_q),
        .size_i     (size_q),
        .offset_i   (addr_q[1:0]),
        .unsigned_i (unsigned_q),
        .merged_o   (merged),
        .load_o     (load_data)
    );

    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.MemRead    = (state_q == ST_READ);
        bus.MemWrite   = (state_q == ST_WRITE);
        bus.Address    = '0;
        bus.WriteData  = '0;
        bus.resp_valid = (state_q == ST_RESP);
        bus.resp_err   = (state_q == ST_RESP) && err_q;
        bus.resp_rdata = '0;
        if (state_q == ST_READ || state_q == ST_WRITE) bus.Address = {2'b00, addr_q[31:2]};
        if (state_q == ST_WRITE) bus.WriteData = merged;
        if (state_q == ST_RESP && !err_q && !write_q) bus.resp_rdata = load_data;
    end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DEPTH, default 128, words in the attached data memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  LSU can accept a request; high only in IDLE.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle response pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  request rejected: misaligned, illegal size, or out of range.
REQ-014 MemRead  output  1  memory read enable.
REQ-015 MemWrite  output  1  memory write enable.
REQ-016 Address  output  32  word index, equal to req_addr[31:2].
REQ-017 WriteData  output  32  word to write.
REQ-018 ReadData  input  32  word from memory, combinationally valid while MemRead=1.

Function
REQ-019 FSM states: IDLE, READ, WRITE, RESP.
REQ-020 A request is accepted when req_valid=1 and req_ready=1; addr, size, write, unsigned and wdata are registered at acceptance.
REQ-021 Error check at acceptance: halfword needs addr[0]=0, word needs addr[1:0]=00, size 11 is illegal, and addr[31:2] must be less than DEPTH; on failure go IDLE->RESP with resp_err=1 and assert no memory strobe.
REQ-022 Load of any size: IDLE->READ->RESP; ReadData is captured at the end of READ; resp_valid is asserted 2 cycles after acceptance.
REQ-023 Word store: IDLE->WRITE->RESP; WriteData equals req_wdata.
REQ-024 Byte or halfword store uses read-modify-write: IDLE->READ->WRITE->RESP; only the addressed lanes are replaced, the other lanes keep the captured word; resp_valid is asserted 3 cycles after acceptance.
REQ-025 Lane selection is little-endian: byte lane = addr[1:0], halfword lane = addr[1].
REQ-026 Load extension: the selected byte or half is sign-extended when req_unsigned=0 and zero-extended when req_unsigned=1; a word load returns the word unchanged.
REQ-027 MemRead=1 only in READ and MemWrite=1 only in WRITE; the two are never high in the same cycle.
REQ-028 Address and WriteData hold their values for the full READ/WRITE cycle; in other states Address=0 and WriteData=0.
REQ-029 RESP lasts exactly one cycle, then IDLE; there is no response backpressure.
REQ-030 req_ready=0 in READ, WRITE and RESP; req_valid in those states is ignored and the CPU holds it.
REQ-031 Back-to-back requests: a new request can be accepted in the cycle after RESP.

Reset
REQ-032 While rst=1 at a clock edge: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0, MemWrite=0, and all captured registers=0.
REQ-033 Reset in READ or WRITE aborts the transaction: no MemWrite is asserted in the following cycle and no response is produced.
REQ-034 req_ready=1 in the first cycle after rst deasserts.

Structure
REQ-035 The state encoding, size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and DEPTH default belong in shared package mem_pkg.
REQ-036 The lane merge and extension logic belongs in one combinational sub-module, mem_lane_align.

Verification
REQ-037 Word store addr 0x10, data 0xDEADBEEF, then word load addr 0x10 -> MemWrite with Address=4; load resp_rdata=0xDEADBEEF, resp_err=0, response 2 cycles after acceptance.
REQ-038 With word 4 = 0xDEADBEEF: byte store addr 0x11, data 0x55 -> READ then WRITE with WriteData=0xDEAD55EF; response 3 cycles after acceptance.
REQ-039 With word 4 = 0xDEAD55EF: signed byte load addr 0x13 returns 0xFFFFFFDE; unsigned returns 0x000000DE; signed half load addr 0x12 returns 0xFFFFDEAD.
REQ-040 Half load addr 0x01, word store addr 0x202 (index 128), and size 11 -> each gives resp_err=1 and resp_rdata=0, with MemRead=MemWrite=0 throughout.
REQ-041 rst=1 in the READ cycle of a byte store -> no MemWrite, no resp_valid, memory word unchanged; req_ready=1 on the cycle after release.
